// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths,
// default boot address and the fetch-state encoding.
package ifetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch unit: issues one word read at a time, hands the result to
// decode with a valid/ready hold, and follows redirects, halts and traps.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_ren,
    output logic [XLEN-1:0] o_imem_raddr,
    input  logic            i_imem_valid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_halt,
    output logic            o_fetch_trap,
    output logic            o_halted
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next, pc_plus;
    logic [XLEN-1:0] inst_next, inst_pc_next;
    logic            inst_valid_next, trap_next;
    logic            target_misaligned;

    assign pc_plus           = pc + XLEN'(INST_BYTES);
    assign target_misaligned = (i_redirect_target[1:0] != 2'b00);

    assign o_imem_ren   = (state == REQ);
    assign o_imem_raddr = (state == REQ) ? pc : '0;
    assign o_halted     = (state == HALTED);

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        inst_next       = o_inst;
        inst_pc_next    = o_inst_pc;
        inst_valid_next = o_inst_valid;
        trap_next       = o_fetch_trap;

        // Halt beats any redirect; a bad redirect target stops fetch for good.
        if (i_halt) begin
            inst_valid_next = 1'b0;
            state_next      = HALTED;
        end else if (state != HALTED && i_redirect && target_misaligned) begin
            trap_next       = 1'b1;
            inst_valid_next = 1'b0;
            state_next      = HALTED;
        end else begin
            case (state)
                IDLE: begin
                    state_next = REQ;
                    if (i_redirect) begin
                        pc_next = i_redirect_target;
                    end
                end
                REQ: begin
                    state_next = WAIT;
                    if (i_redirect) begin
                        pc_next         = i_redirect_target;
                        inst_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
                WAIT: begin
                    if (i_redirect) begin
                        pc_next    = i_redirect_target;
                        state_next = i_imem_valid ? REQ : DRAIN;
                    end else if (i_imem_valid) begin
                        inst_next       = i_imem_rdata;
                        inst_pc_next    = pc;
                        inst_valid_next = 1'b1;
                        pc_next         = pc_plus;
                        state_next      = HOLD;
                    end
                end
                HOLD: begin
                    if (i_redirect) begin
                        pc_next         = i_redirect_target;
                        inst_valid_next = 1'b0;
                        state_next      = REQ;
                    end else if (i_inst_ready) begin
                        inst_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
                // The stale response is swallowed here before fetching resumes.
                DRAIN: begin
                    if (i_redirect) begin
                        pc_next = i_redirect_target;
                    end
                    if (i_imem_valid) begin
                        state_next = REQ;
                    end
                end
                HALTED: begin
                    state_next = HALTED;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            pc           <= RESET_ADDR;
            o_inst       <= '0;
            o_inst_pc    <= '0;
            o_inst_valid <= 1'b0;
            o_fetch_trap <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            o_inst       <= inst_next;
            o_inst_pc    <= inst_pc_next;
            o_inst_valid <= inst_valid_next;
            o_fetch_trap <= trap_next;
        end
    end

endmodule
